// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the register-file slave.
// Carries the AW/W/B write channels and the AR/R read channels;
// clock and reset are kept as plain ports on the modules.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] S_AWADDR;
    logic                  S_AWVALID;
    logic                  S_AWREADY;
    logic [DATA_WIDTH-1:0] S_WDATA;
    logic                  S_WVALID;
    logic                  S_WREADY;
    logic                  S_BVALID;
    logic                  S_BREADY;
    logic                  S_BRESP;
    logic [ADDR_WIDTH-1:0] S_ARADDR;
    logic                  S_ARVALID;
    logic                  S_ARREADY;
    logic [DATA_WIDTH-1:0] S_RDATA;
    logic                  S_RVALID;
    logic                  S_RREADY;
    logic                  S_RRESP;

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
        input  S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
        output S_ARREADY, S_RDATA, S_RVALID, S_RRESP
    );

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
        output S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
        input  S_ARREADY, S_RDATA, S_RVALID, S_RRESP
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file: six read/write words, a read-only
// count of successful writes (word 6) and a read-only ID (word 7).
// Write and read paths are independent FSMs with registered outputs.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA11E_0001
) (
    input logic ACLK,
    input logic ARESETN,
    axi_lite_slave_regs_if.slave s_axi
);

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic                  aw_ready, aw_ready_next;
    logic                  w_ready, w_ready_next;
    logic                  aw_held, aw_held_next;
    logic                  w_held, w_held_next;
    logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_next;
    logic [DATA_WIDTH-1:0] w_data, w_data_next;
    logic                  bvalid, bvalid_next;
    logic                  bresp, bresp_next;
    logic                  commit;
    logic                  commit_err;

    logic                  ar_ready, ar_ready_next;
    logic                  rvalid, rvalid_next;
    logic                  rresp, rresp_next;
    logic [DATA_WIDTH-1:0] rdata, rdata_next;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_misaligned;

    logic [DATA_WIDTH-1:0] rw_regs [0:5];
    logic [DATA_WIDTH-1:0] wcount;

    // Misaligned addresses and the read-only words 6/7 reject the write.
    assign commit_err = (aw_addr[1:0] != 2'b00) || (aw_addr[4:3] == 2'b11);
    assign rd_misaligned = (s_axi.S_ARADDR[1:0] != 2'b00);

    // Write path: collect AW and W into holding registers, commit once both are held, then respond.
    always_comb begin
        w_state_next = w_state;
        aw_ready_next = aw_ready;
        w_ready_next = w_ready;
        aw_held_next = aw_held;
        w_held_next = w_held;
        aw_addr_next = aw_addr;
        w_data_next = w_data;
        bvalid_next = bvalid;
        bresp_next = bresp;
        commit = 1'b0;
        case (w_state)
            W_ACCEPT: begin
                if (aw_held && w_held) begin
                    commit = 1'b1;
                    aw_held_next = 1'b0;
                    w_held_next = 1'b0;
                    aw_ready_next = 1'b0;
                    w_ready_next = 1'b0;
                    bvalid_next = 1'b1;
                    bresp_next = commit_err;
                    w_state_next = W_RESP;
                end else begin
                    if (s_axi.S_AWVALID && aw_ready) begin
                        aw_held_next = 1'b1;
                        aw_addr_next = s_axi.S_AWADDR;
                    end
                    if (s_axi.S_WVALID && w_ready) begin
                        w_held_next = 1'b1;
                        w_data_next = s_axi.S_WDATA;
                    end
                    aw_ready_next = !aw_held_next;
                    w_ready_next = !w_held_next;
                end
            end
            W_RESP: begin
                if (s_axi.S_BREADY) begin
                    bvalid_next = 1'b0;
                    bresp_next = 1'b0;
                    aw_ready_next = 1'b1;
                    w_ready_next = 1'b1;
                    w_state_next = W_ACCEPT;
                end
            end
            default: w_state_next = W_ACCEPT;
        endcase
    end

    // Write path state and registered outputs; reset drops any half-collected transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_ACCEPT;
            aw_ready <= 1'b0;
            w_ready <= 1'b0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            bvalid <= 1'b0;
            bresp <= 1'b0;
        end else begin
            w_state <= w_state_next;
            aw_ready <= aw_ready_next;
            w_ready <= w_ready_next;
            aw_held <= aw_held_next;
            w_held <= w_held_next;
            aw_addr <= aw_addr_next;
            w_data <= w_data_next;
            bvalid <= bvalid_next;
            bresp <= bresp_next;
        end
    end

    // Register storage and write counter, updated only by an accepted commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 6; i++) begin
                rw_regs[i] <= '0;
            end
            wcount <= '0;
        end else if (commit && !commit_err) begin
            for (int i = 0; i < 6; i++) begin
                if (aw_addr[4:2] == 3'(i)) begin
                    rw_regs[i] <= w_data;
                end
            end
            wcount <= wcount + DATA_WIDTH'(1);
        end
    end

    // Read mux: selects the word addressed by the incoming AR channel.
    always_comb begin
        rd_word = '0;
        case (s_axi.S_ARADDR[4:2])
            3'd0: rd_word = rw_regs[0];
            3'd1: rd_word = rw_regs[1];
            3'd2: rd_word = rw_regs[2];
            3'd3: rd_word = rw_regs[3];
            3'd4: rd_word = rw_regs[4];
            3'd5: rd_word = rw_regs[5];
            3'd6: rd_word = wcount;
            3'd7: rd_word = ID_VALUE;
            default: rd_word = '0;
        endcase
    end

    // Read path: capture the selected word on the AR handshake and hold it until RREADY.
    always_comb begin
        r_state_next = r_state;
        ar_ready_next = ar_ready;
        rvalid_next = rvalid;
        rdata_next = rdata;
        rresp_next = rresp;
        case (r_state)
            R_ACCEPT: begin
                ar_ready_next = 1'b1;
                if (s_axi.S_ARVALID && ar_ready) begin
                    ar_ready_next = 1'b0;
                    rvalid_next = 1'b1;
                    rdata_next = rd_misaligned ? '0 : rd_word;
                    rresp_next = rd_misaligned;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_RREADY) begin
                    rvalid_next = 1'b0;
                    ar_ready_next = 1'b1;
                    r_state_next = R_ACCEPT;
                end
            end
            default: r_state_next = R_ACCEPT;
        endcase
    end

    // Read path state and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_ACCEPT;
            ar_ready <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
            rresp <= 1'b0;
        end else begin
            r_state <= r_state_next;
            ar_ready <= ar_ready_next;
            rvalid <= rvalid_next;
            rdata <= rdata_next;
            rresp <= rresp_next;
        end
    end

    assign s_axi.S_AWREADY = aw_ready;
    assign s_axi.S_WREADY = w_ready;
    assign s_axi.S_BVALID = bvalid;
    assign s_axi.S_BRESP = bresp;
    assign s_axi.S_ARREADY = ar_ready;
    assign s_axi.S_RVALID = rvalid;
    assign s_axi.S_RDATA = rdata;
    assign s_axi.S_RRESP = rresp;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed testbench for the AXI4-Lite register-file slave.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_lite_slave_regs;

    localparam logic [31:0] ID_CONST = 32'hA11E_0001;

    logic ACLK;
    logic ARESETN;
    int   check_count;
    int   pass_count;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

    axi_lite_slave_regs #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .ID_VALUE(ID_CONST)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .s_axi(axi.slave)
    );

    // Free-running 100MHz clock.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            pass_count++;
        end
    endtask

    // One complete write (is_write=1, expect = BRESP) or read (expect = RDATA, exp_resp = RRESP).
    task automatic apply_stimulus(input bit is_write, input logic [4:0] addr, input logic [31:0] data,
                                  input logic exp_resp, input string tag);
        int  n;
        bit  aw_hs;
        bit  w_hs;
        bit  ar_hs;
        if (is_write) begin
            axi.S_AWADDR = addr;
            axi.S_WDATA = data;
            axi.S_AWVALID = 1'b1;
            axi.S_WVALID = 1'b1;
            axi.S_BREADY = 1'b1;
            n = 0;
            while ((axi.S_AWVALID || axi.S_WVALID) && n < 10) begin
                aw_hs = axi.S_AWVALID && axi.S_AWREADY;
                w_hs = axi.S_WVALID && axi.S_WREADY;
                tick();
                if (aw_hs) axi.S_AWVALID = 1'b0;
                if (w_hs) axi.S_WVALID = 1'b0;
                n++;
            end
            check_output({tag, " accepted"}, {31'b0, !(axi.S_AWVALID || axi.S_WVALID)}, 32'd1);
            axi.S_AWVALID = 1'b0;
            axi.S_WVALID = 1'b0;
            n = 0;
            while (!axi.S_BVALID && n < 10) begin
                tick();
                n++;
            end
            check_output({tag, " bvalid"}, {31'b0, axi.S_BVALID}, 32'd1);
            check_output({tag, " bresp"}, {31'b0, axi.S_BRESP}, {31'b0, exp_resp});
            tick();
        end else begin
            axi.S_ARADDR = addr;
            axi.S_ARVALID = 1'b1;
            axi.S_RREADY = 1'b1;
            n = 0;
            while (axi.S_ARVALID && n < 10) begin
                ar_hs = axi.S_ARREADY;
                tick();
                if (ar_hs) axi.S_ARVALID = 1'b0;
                n++;
            end
            axi.S_ARVALID = 1'b0;
            n = 0;
            while (!axi.S_RVALID && n < 10) begin
                tick();
                n++;
            end
            check_output({tag, " rvalid"}, {31'b0, axi.S_RVALID}, 32'd1);
            check_output({tag, " rdata"}, axi.S_RDATA, data);
            check_output({tag, " rresp"}, {31'b0, axi.S_RRESP}, {31'b0, exp_resp});
            tick();
        end
    endtask

    // Main directed sequence.
    initial begin
        check_count = 0;
        pass_count = 0;
        ARESETN = 1'b0;
        axi.S_AWADDR = '0;
        axi.S_AWVALID = 1'b0;
        axi.S_WDATA = '0;
        axi.S_WVALID = 1'b0;
        axi.S_BREADY = 1'b0;
        axi.S_ARADDR = '0;
        axi.S_ARVALID = 1'b0;
        axi.S_RREADY = 1'b0;

        // Reset state
        tick();
        tick();
        check_output("rst bvalid", {31'b0, axi.S_BVALID}, 32'd0);
        check_output("rst rvalid", {31'b0, axi.S_RVALID}, 32'd0);
        check_output("rst rdata", axi.S_RDATA, 32'd0);
        check_output("rst awready", {31'b0, axi.S_AWREADY}, 32'd0);
        ARESETN = 1'b1;
        tick();
        check_output("post awready", {31'b0, axi.S_AWREADY}, 32'd1);
        check_output("post wready", {31'b0, axi.S_WREADY}, 32'd1);
        check_output("post arready", {31'b0, axi.S_ARREADY}, 32'd1);
        check_output("post bvalid", {31'b0, axi.S_BVALID}, 32'd0);
        apply_stimulus(1'b0, 5'h1C, ID_CONST, 1'b0, "read id");

        // AW and W in the same cycle: BVALID two cycles later
        axi.S_AWADDR = 5'h04;
        axi.S_WDATA = 32'hDEADBEEF;
        axi.S_AWVALID = 1'b1;
        axi.S_WVALID = 1'b1;
        axi.S_BREADY = 1'b1;
        tick();
        axi.S_AWVALID = 1'b0;
        axi.S_WVALID = 1'b0;
        check_output("same bvalid n+1", {31'b0, axi.S_BVALID}, 32'd0);
        tick();
        check_output("same bvalid n+2", {31'b0, axi.S_BVALID}, 32'd1);
        check_output("same bresp", {31'b0, axi.S_BRESP}, 32'd0);
        tick();
        check_output("same bvalid drop", {31'b0, axi.S_BVALID}, 32'd0);
        check_output("same awready back", {31'b0, axi.S_AWREADY}, 32'd1);
        apply_stimulus(1'b0, 5'h04, 32'hDEADBEEF, 1'b0, "read w1");
        apply_stimulus(1'b0, 5'h18, 32'd1, 1'b0, "wcount 1");

        // W three cycles ahead of AW
        axi.S_WDATA = 32'h12345678;
        axi.S_WVALID = 1'b1;
        tick();
        axi.S_WVALID = 1'b0;
        check_output("early wready drop", {31'b0, axi.S_WREADY}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check_output("early no bvalid", {31'b0, axi.S_BVALID}, 32'd0);
            tick();
        end
        axi.S_AWADDR = 5'h08;
        axi.S_AWVALID = 1'b1;
        check_output("early no bvalid aw", {31'b0, axi.S_BVALID}, 32'd0);
        tick();
        axi.S_AWVALID = 1'b0;
        check_output("early no bvalid commit", {31'b0, axi.S_BVALID}, 32'd0);
        tick();
        check_output("early bvalid", {31'b0, axi.S_BVALID}, 32'd1);
        check_output("early bresp", {31'b0, axi.S_BRESP}, 32'd0);
        tick();
        apply_stimulus(1'b0, 5'h08, 32'h12345678, 1'b0, "read w2");

        // Rejected accesses
        apply_stimulus(1'b1, 5'h1C, 32'hFFFF0000, 1'b1, "write id");
        apply_stimulus(1'b1, 5'h05, 32'h0000FFFF, 1'b1, "write misaligned");
        apply_stimulus(1'b0, 5'h06, 32'd0, 1'b1, "read misaligned");
        apply_stimulus(1'b0, 5'h1C, ID_CONST, 1'b0, "id intact");
        apply_stimulus(1'b0, 5'h18, 32'd2, 1'b0, "wcount 2");

        // Write response stalled by BREADY while a read proceeds
        axi.S_BREADY = 1'b0;
        axi.S_AWADDR = 5'h0C;
        axi.S_WDATA = 32'hCAFEF00D;
        axi.S_AWVALID = 1'b1;
        axi.S_WVALID = 1'b1;
        tick();
        axi.S_AWVALID = 1'b0;
        axi.S_WVALID = 1'b0;
        tick();
        axi.S_ARADDR = 5'h04;
        axi.S_ARVALID = 1'b1;
        axi.S_RREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("stall bvalid", {31'b0, axi.S_BVALID}, 32'd1);
            check_output("stall bresp", {31'b0, axi.S_BRESP}, 32'd0);
            check_output("stall awready", {31'b0, axi.S_AWREADY}, 32'd0);
            check_output("stall wready", {31'b0, axi.S_WREADY}, 32'd0);
            if (i == 1) begin
                check_output("stall rvalid", {31'b0, axi.S_RVALID}, 32'd1);
                check_output("stall rdata", axi.S_RDATA, 32'hDEADBEEF);
                check_output("stall arready", {31'b0, axi.S_ARREADY}, 32'd0);
            end
            if (i == 2) begin
                check_output("stall rvalid drop", {31'b0, axi.S_RVALID}, 32'd0);
                check_output("stall arready back", {31'b0, axi.S_ARREADY}, 32'd1);
            end
            tick();
            axi.S_ARVALID = 1'b0;
        end
        axi.S_BREADY = 1'b1;
        tick();
        check_output("stall release bvalid", {31'b0, axi.S_BVALID}, 32'd0);
        apply_stimulus(1'b0, 5'h0C, 32'hCAFEF00D, 1'b0, "read w3");

        // Read sampled on the same edge as a commit to that word sees the old value
        axi.S_AWADDR = 5'h04;
        axi.S_WDATA = 32'h55AA55AA;
        axi.S_AWVALID = 1'b1;
        axi.S_WVALID = 1'b1;
        axi.S_RREADY = 1'b0;
        tick();
        axi.S_AWVALID = 1'b0;
        axi.S_WVALID = 1'b0;
        axi.S_ARADDR = 5'h04;
        axi.S_ARVALID = 1'b1;
        tick();
        axi.S_ARVALID = 1'b0;
        check_output("race rvalid", {31'b0, axi.S_RVALID}, 32'd1);
        check_output("race rdata old", axi.S_RDATA, 32'hDEADBEEF);
        check_output("race bvalid", {31'b0, axi.S_BVALID}, 32'd1);
        axi.S_RREADY = 1'b1;
        tick();
        apply_stimulus(1'b0, 5'h04, 32'h55AA55AA, 1'b0, "race rdata new");
        apply_stimulus(1'b0, 5'h18, 32'd4, 1'b0, "wcount 4");

        // Reset with a read response pending and AW held waiting for W
        axi.S_RREADY = 1'b0;
        axi.S_ARADDR = 5'h1C;
        axi.S_ARVALID = 1'b1;
        tick();
        axi.S_ARVALID = 1'b0;
        axi.S_AWADDR = 5'h10;
        axi.S_AWVALID = 1'b1;
        check_output("pre-rst rvalid", {31'b0, axi.S_RVALID}, 32'd1);
        tick();
        axi.S_AWVALID = 1'b0;
        check_output("pre-rst aw held", {31'b0, axi.S_AWREADY}, 32'd0);
        #2;
        ARESETN = 1'b0;
        #1;
        check_output("async rvalid", {31'b0, axi.S_RVALID}, 32'd0);
        check_output("async rdata", axi.S_RDATA, 32'd0);
        check_output("async arready", {31'b0, axi.S_ARREADY}, 32'd0);
        tick();
        ARESETN = 1'b1;
        tick();
        tick();
        check_output("after rst bvalid", {31'b0, axi.S_BVALID}, 32'd0);
        apply_stimulus(1'b0, 5'h04, 32'd0, 1'b0, "rst reg1");
        apply_stimulus(1'b0, 5'h08, 32'd0, 1'b0, "rst reg2");
        apply_stimulus(1'b0, 5'h0C, 32'd0, 1'b0, "rst reg3");
        apply_stimulus(1'b0, 5'h18, 32'd0, 1'b0, "rst wcount");
        axi.S_BREADY = 1'b1;
        axi.S_WDATA = 32'h00000077;
        axi.S_WVALID = 1'b1;
        tick();
        axi.S_WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("aborted aw no bvalid", {31'b0, axi.S_BVALID}, 32'd0);
            tick();
        end
        apply_stimulus(1'b0, 5'h10, 32'd0, 1'b0, "rst reg4");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
